// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: drives pulsed set/reset commands to an external SR flip-flop
// and confirms the target level from q_fb, reporting done or a timeout error.
module sr_pulse_driver #(
    parameter int PULSE_W = 2,
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic s,
    output logic r,
    input  logic q_fb,
    output logic done,
    output logic err,
    output logic err_sticky,
    input  logic clr_err
);
    localparam logic [1:0] IDLE = 2'd0, PULSE = 2'd1, WAIT = 2'd2, FINISH = 2'd3;
    localparam int MAXC = PULSE_W > TIMEOUT ? PULSE_W : TIMEOUT;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] P_LOAD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] T_LOAD = CW'(TIMEOUT - 1);
    logic [1:0] state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic target, target_n, s_n, r_n, done_n, err_n, accept, cnt_zero;
    assign req_ready = state == IDLE;
    assign accept = req_valid && req_ready;
    assign cnt_zero = cnt == '0;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        target_n = target;
        s_n = 1'b0;
        r_n = 1'b0;
        done_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: if (accept) begin
                target_n = req_level;
                if (q_fb == req_level) begin
                    state_n = FINISH;
                    done_n = 1'b1;
                end else begin
                    state_n = PULSE;
                    cnt_n = P_LOAD;
                    s_n = req_level;
                    r_n = !req_level;
                end
            end
            // q_fb is deliberately ignored while the pulse is being driven
            PULSE: if (cnt_zero) begin
                state_n = WAIT;
                cnt_n = T_LOAD;
            end else begin
                cnt_n = cnt - CW'(1);
                s_n = target;
                r_n = !target;
            end
            WAIT: if (q_fb == target) begin
                state_n = FINISH;
                done_n = 1'b1;
            end else if (cnt_zero) begin
                state_n = FINISH;
                err_n = 1'b1;
            end else begin
                cnt_n = cnt - CW'(1);
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            target <= 1'b0;
            s <= 1'b0;
            r <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            target <= target_n;
            s <= s_n;
            r <= r_n;
            done <= done_n;
            err <= err_n;
            // a timeout in flight or being reported beats a simultaneous clear
            err_sticky <= err_n || err || (err_sticky && !clr_err);
        end
    end
endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver: vector table, directed corner sequences and random traffic
// on two parameterisations, each checked against a transaction-level model.
module tb_sr_pulse_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rv = 1'b0, rl = 1'b0, q = 1'b0, clr = 1'b0;
    logic rdy0, s0, r0, done0, err0, st0;
    logic rdy1, s1, r1, done1, err1, st1;
    logic [5:0] o0, o1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_pulse_driver d0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_level(rl), .req_ready(rdy0),
        .s(s0), .r(r0), .q_fb(q), .done(done0), .err(err0), .err_sticky(st0), .clr_err(clr)
    );
    sr_pulse_driver #(.PULSE_W(1), .TIMEOUT(1)) d1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_level(rl), .req_ready(rdy1),
        .s(s1), .r(r1), .q_fb(q), .done(done1), .err(err1), .err_sticky(st1), .clr_err(clr)
    );
    assign o0 = {rdy0, s0, r0, done0, err0, st0};
    assign o1 = {rdy1, s1, r1, done1, err1, st1};

    // Model: one transaction at a time, tracked by edges elapsed since acceptance.
    typedef struct {
        bit busy; bit quick; bit tgt; int n; int fin;
        bit s; bit r; bit done; bit err; bit sticky;
    } mdl_t;
    mdl_t m0, m1, mz;

    function automatic mdl_t step(mdl_t mi, int pw, int to, bit v, bit lv, bit qf, bit c);
        mdl_t m;
        bit prev_err;
        m = mi;
        prev_err = m.err;
        m.s = 0; m.r = 0; m.done = 0; m.err = 0;
        if (!m.busy) begin
            if (v) begin
                m.busy = 1; m.tgt = lv; m.n = 0; m.fin = -1; m.quick = (qf == lv);
                if (m.quick) begin m.done = 1; m.fin = 0; end
                else begin m.s = lv; m.r = !lv; end
            end
        end else begin
            m.n++;
            if (m.fin >= 0 && m.n == m.fin + 1) m.busy = 0;
            else if (!m.quick && m.n < pw) begin m.s = m.tgt; m.r = !m.tgt; end
            else if (!m.quick && m.n > pw && m.n <= pw + to) begin
                if (qf == m.tgt) begin m.done = 1; m.fin = m.n; end
                else if (m.n == pw + to) begin m.err = 1; m.fin = m.n; end
            end
        end
        if (m.err) m.sticky = 1;
        else if (c && !prev_err) m.sticky = 0;
        return m;
    endfunction

    function automatic logic [5:0] pk(mdl_t m);
        return {!m.busy, m.s, m.r, m.done, m.err, m.sticky};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m0 = step(m0, 2, 8, rv, rl, q, clr);
            m1 = step(m1, 1, 1, rv, rl, q, clr);
        end else begin
            m0 = mz; m1 = mz;
        end
        #1;
        chk("model_d0", 32'(o0), 32'(pk(m0)));
        chk("model_d1", 32'(o1), 32'(pk(m1)));
        chk("mutex_d0", 32'(s0 & r0), 32'(0));
        chk("mutex_d1", 32'(s1 & r1), 32'(0));
    endtask

    task automatic idle(int n);
        rv = 0; clr = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct { bit v; bit lv; bit qf; bit c; logic [5:0] exp; } vec_t;
    vec_t tbl[12];

    initial begin
        int k, acc;
        bit saw_done, saw_any, prev_rdy;
        mz = '{busy: 0, quick: 0, tgt: 0, n: 0, fin: -1, s: 0, r: 0, done: 0, err: 0, sticky: 0};
        m0 = mz; m1 = mz;
        // {ready, s, r, done, err, err_sticky} for the default instance
        tbl[0]  = '{1, 1, 0, 0, 6'b010000};
        tbl[1]  = '{0, 1, 0, 0, 6'b010000};
        tbl[2]  = '{0, 1, 0, 0, 6'b000000};
        tbl[3]  = '{0, 1, 1, 0, 6'b000100};
        tbl[4]  = '{0, 1, 1, 0, 6'b100000};
        tbl[5]  = '{1, 1, 1, 0, 6'b000100};
        tbl[6]  = '{0, 1, 1, 0, 6'b100000};
        tbl[7]  = '{1, 0, 1, 0, 6'b001000};
        tbl[8]  = '{0, 0, 1, 0, 6'b001000};
        tbl[9]  = '{0, 0, 0, 0, 6'b000000};
        tbl[10] = '{0, 0, 0, 0, 6'b000100};
        tbl[11] = '{0, 0, 0, 0, 6'b100000};

        #1;
        chk("reset_d0", 32'(o0), 32'(6'b100000));
        chk("reset_d1", 32'(o1), 32'(6'b100000));
        tick(); tick();
        rst_n = 1;

        for (int i = 0; i < 12; i++) begin
            rv = tbl[i].v; rl = tbl[i].lv; q = tbl[i].qf; clr = tbl[i].c;
            tick();
            chk($sformatf("vec%0d", i), 32'(o0), 32'(tbl[i].exp));
        end

        // timeout: q stuck low
        idle(15);
        q = 0; rv = 1; rl = 1;
        tick();
        rv = 0; k = 0; saw_done = 0;
        while (!err0 && k < 20) begin
            tick(); k++;
            if (done0) saw_done = 1;
        end
        chk("timeout_cycle", 32'(k), 32'(10));
        chk("timeout_no_done", 32'(saw_done), 32'(0));
        tick(); tick(); tick();
        chk("sticky_held", 32'(st0), 32'(1));
        clr = 1;
        tick();
        clr = 0;
        chk("sticky_cleared", 32'(st0), 32'(0));

        // reset during the second pulse cycle
        idle(15);
        q = 0; rv = 1; rl = 1;
        tick();
        rv = 0;
        tick();
        chk("second_pulse_s", 32'(s0), 32'(1));
        rst_n = 0;
        #1;
        m0 = mz; m1 = mz;
        chk("async_reset_d0", 32'(o0), 32'(6'b100000));
        chk("async_reset_d1", 32'(o1), 32'(6'b100000));
        tick(); tick();
        rst_n = 1;
        saw_any = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done0 || err0) saw_any = 1;
        end
        chk("abort_silent", 32'(saw_any), 32'(0));

        // req_valid held high, q emulates the flip-flop driven by d0
        idle(15);
        q = 0; rv = 1; rl = 1; acc = 0; prev_rdy = 0;
        for (int i = 0; i < 60; i++) begin
            bit pre;
            pre = rdy0;
            tick();
            chk("one_accept_per_idle", 32'(rdy0 & prev_rdy), 32'(0));
            prev_rdy = rdy0;
            if (pre) begin acc++; rl = !rl; end
            q = s0 ? 1'b1 : r0 ? 1'b0 : q;
        end
        chk("accept_count", 32'(acc >= 10), 32'(1));

        // PULSE_W=1/TIMEOUT=1: q one cycle late errors, q in time succeeds
        idle(15);
        q = 0; rv = 1; rl = 1;
        tick();
        rv = 0;
        tick(); tick();
        q = 1;
        chk("late_err", 32'(err1), 32'(1));
        chk("late_no_done", 32'(done1), 32'(0));
        idle(15);
        q = 0; rv = 1; rl = 1;
        tick();
        rv = 0;
        tick();
        q = 1;
        tick();
        chk("ontime_done", 32'(done1), 32'(1));
        chk("ontime_no_err", 32'(err1), 32'(0));

        idle(15);
        for (int i = 0; i < 400; i++) begin
            rv = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            q = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 9) == 0);
            tick();
        end
        idle(15);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sr_pulse_driver.md
SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

Interface
REQ-001 The block SHALL have parameter PULSE_W, default 2, setting the number of cycles an s/r pulse is held high (legal range 1..15).
REQ-002 The block SHALL have parameter TIMEOUT, default 8, setting the maximum number of cycles to wait for q_fb confirmation after a pulse (legal range 1..255).
REQ-003 The block SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  input  1  requests a new target level.
REQ-006 The block SHALL have port req_level  input  1  target level for the external flip-flop q (1 = set, 0 = reset).
REQ-007 The block SHALL have port req_ready  output  1  high when a request can be accepted.
REQ-008 The block SHALL have port s  output  1  registered set command to the external SR flip-flop.
REQ-009 The block SHALL have port r  output  1  registered reset command to the external SR flip-flop.
REQ-010 The block SHALL have port q_fb  input  1  q of the external flip-flop (same clock domain, no synchronizer).
REQ-011 The block SHALL have port done  output  1  one-cycle pulse: target level confirmed.
REQ-012 The block SHALL have port err  output  1  one-cycle pulse: confirmation timed out.
REQ-013 The block SHALL have port err_sticky  output  1  set by any timeout and held until clr_err.
REQ-014 The block SHALL have port clr_err  input  1  synchronous clear of err_sticky.

Function
REQ-015 The FSM SHALL have states IDLE, PULSE, WAIT and FINISH, with req_ready = 1 only in IDLE.
REQ-016 A request SHALL be accepted on the rising edge where req_valid = 1 and req_ready = 1, capturing req_level into an internal target register.
REQ-017 On acceptance with q_fb == req_level, the FSM SHALL go to FINISH with no s/r pulse, giving done = 1 on the next cycle.
REQ-018 On acceptance with q_fb != req_level, the FSM SHALL go to PULSE; s (target 1) or r (target 0) SHALL be high for exactly PULSE_W cycles, starting the cycle after acceptance.
REQ-019 s and r SHALL never be 1 in the same cycle, in any state or during reset.
REQ-020 q_fb SHALL be ignored in PULSE; after PULSE_W cycles the FSM SHALL go to WAIT with s = r = 0.
REQ-021 In WAIT, q_fb SHALL be sampled every cycle; the first cycle with q_fb == target SHALL move the FSM to FINISH.
REQ-022 If q_fb != target for TIMEOUT consecutive WAIT cycles, the FSM SHALL go to FINISH in error mode.
REQ-023 In FINISH, the block SHALL pulse done (success) or err (timeout) for exactly one cycle, then return to IDLE; done and err SHALL be mutually exclusive.
REQ-024 err_sticky SHALL be set in the cycle err = 1; if clr_err and err coincide, the set SHALL win.
REQ-025 Counters SHALL be sized for max(PULSE_W, TIMEOUT) and SHALL not wrap; each SHALL reload on entry to its state.
REQ-026 A request arriving while req_ready = 0 SHALL be ignored, not queued.
REQ-027 A request accepted on the same edge FINISH exits SHALL not occur, because req_ready is registered low in FINISH.

Reset
REQ-028 While rst_n = 0, the block SHALL be in IDLE with s = 0, r = 0, done = 0, err = 0, err_sticky = 0, req_ready = 1, counters = 0 and target = 0, regardless of clk.
REQ-029 Reset asserted mid-PULSE SHALL drop s/r to 0 asynchronously; after release the block SHALL resume in IDLE, with the aborted request producing neither done nor err.

Verification
REQ-030 The bench SHALL check: defaults, q_fb = 0, request level 1, q_fb rises 1 cycle after pulse -> s high cycles 1-2 after accept, r = 0 throughout, done at the first cycle after confirmation, req_ready back to 1.
REQ-031 The bench SHALL check: q_fb = 1, request level 1 -> no s/r activity, done one cycle after accept.
REQ-032 The bench SHALL check: q_fb stuck 0, request level 1, TIMEOUT = 8 -> err pulse after 2 pulse + 8 wait cycles, err_sticky = 1 until clr_err, done never asserted.
REQ-033 The bench SHALL check: rst_n low during the second pulse cycle -> s = 0 immediately, all outputs at reset values, and no done/err after release.
REQ-034 The bench SHALL check: req_valid held high through a whole transaction with alternating levels -> exactly one acceptance per IDLE visit, s/r never simultaneously high.
REQ-035 The bench SHALL check: PULSE_W = 1, TIMEOUT = 1 with q_fb responding one cycle late -> err asserted, and the boundary honoured exactly.
